// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with hold limit and forced release
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    state_t     state, state_n;
    logic [2:0] ptr, ptr_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] gnt_n;
    logic [2:0] idx_n;
    logic       busy_n;
    logic       timeout_n;

    logic [2:0] win_idx;
    logic [2:0] cand;
    logic       found;
    logic       release_normal;
    logic       release_limit;

    // Rotating-priority search starting at ptr.
    always_comb begin
        found   = 1'b0;
        win_idx = ptr;
        cand    = ptr;
        for (int k = 0; k < 8; k++) begin
            cand = ptr + 3'(k);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign release_normal = done || !req[gnt_idx];
    assign release_limit  = (cnt == HOLD_LIMIT);

    // GAP is the single dead cycle; its closing edge performs the IDLE arbitration
    // with the pointer already advanced past the previous owner.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cnt_n     = cnt;
        gnt_n     = gnt;
        idx_n     = gnt_idx;
        busy_n    = busy;
        timeout_n = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (found) begin
                    state_n = GRANT;
                    gnt_n   = 8'(1) << win_idx;
                    idx_n   = win_idx;
                    busy_n  = 1'b1;
                    cnt_n   = 8'd0;
                end else begin
                    state_n = IDLE;
                    gnt_n   = 8'd0;
                    busy_n  = 1'b0;
                end
            end
            GRANT: begin
                if (release_normal || release_limit) begin
                    state_n   = GAP;
                    gnt_n     = 8'd0;
                    busy_n    = 1'b0;
                    ptr_n     = gnt_idx + 3'd1;
                    timeout_n = !release_normal;
                end else if (cnt != 8'hFF) begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 8'd0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 3'd0;
            cnt     <= 8'd0;
            gnt     <= 8'd0;
            gnt_idx <= 3'd0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            gnt     <= gnt_n;
            gnt_idx <= idx_n;
            busy    <= busy_n;
            timeout <= timeout_n;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed and randomized checks of rr_arbiter8 against a reference model
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 15;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       busy;
    logic       timeout;

    int checks;
    int failures;

    // Reference model: owner (-1 = nobody), pointer, cycles the owner has held the grant.
    int m_owner;
    int m_ptr;
    int m_held;
    int m_last;
    bit m_timeout;

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_owner   = -1;
        m_ptr     = 0;
        m_held    = 0;
        m_last    = 0;
        m_timeout = 1'b0;
    endfunction

    function automatic void model_edge(input logic [7:0] r, input logic d);
        bit normal;
        bit picked;
        int c;
        m_timeout = 1'b0;
        if (m_owner >= 0) begin
            normal = d || (r[m_owner] == 1'b0);
            if (normal || m_held == MAX_HOLD) begin
                m_timeout = !normal;
                m_ptr     = (m_owner + 1) % 8;
                m_owner   = -1;
            end else begin
                m_held++;
            end
        end else if (r != 8'd0) begin
            picked = 1'b0;
            for (int k = 0; k < 8; k++) begin
                c = (m_ptr + k) % 8;
                if (!picked && r[c]) begin
                    picked  = 1'b1;
                    m_owner = c;
                    m_last  = c;
                    m_held  = 1;
                end
            end
        end
    endfunction

    task automatic step();
        logic [7:0] exp_gnt;
        model_edge(req, done);
        @(posedge clk);
        #1;
        exp_gnt = (m_owner < 0) ? 8'd0 : (8'(1) << m_owner);
        chk("model_gnt", gnt, exp_gnt);
        chk("model_idx", {5'd0, gnt_idx}, 8'(m_last));
        chk("model_busy", {7'd0, busy}, {7'd0, (m_owner >= 0)});
        chk("model_timeout", {7'd0, timeout}, {7'd0, m_timeout});
        chk("onehot", {7'd0, $onehot0(gnt)}, 8'd1);
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_gnt"}, gnt, 8'd0);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
        chk({tag, "_timeout"}, {7'd0, timeout}, 8'd0);
        model_reset();
        @(posedge clk);
        #1;
        req   = 8'd0;
        done  = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = 8'd0;
        done     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt", gnt, 8'd0);
        chk("reset_idx", {5'd0, gnt_idx}, 8'd0);
        chk("reset_busy", {7'd0, busy}, 8'd0);
        chk("reset_timeout", {7'd0, timeout}, 8'd0);
        rst_n = 1'b1;

        // Single requester, done release, pointer moves to 1
        req = 8'h01;
        step();
        chk("r27_gnt", gnt, 8'h01);
        chk("r27_idx", {5'd0, gnt_idx}, 8'd0);
        chk("r27_busy", {7'd0, busy}, 8'd1);
        done = 1'b1;
        step();
        chk("r27_gap", gnt, 8'd0);
        done = 1'b0;
        req  = 8'h03;
        step();
        chk("r27_ptr1", {5'd0, gnt_idx}, 8'd1);
        req = 8'd0;
        step();
        step();

        // Two requesters alternate with one dead cycle between grants
        do_reset("r28_rst");
        req = 8'h84;
        step();
        for (int g = 0; g < 4; g++) begin
            chk("r28_idx", {5'd0, gnt_idx}, (g % 2 == 0) ? 8'd2 : 8'd7);
            chk("r28_busy", {7'd0, busy}, 8'd1);
            done = 1'b1;
            step();
            chk("r28_zero", gnt, 8'd0);
            done = 1'b0;
            step();
        end

        // All requesting: full rotation including 7 -> 0 wrap
        do_reset("r30_rst");
        req = 8'hFF;
        step();
        for (int g = 0; g < 9; g++) begin
            chk("r30_idx", {5'd0, gnt_idx}, 8'(g % 8));
            done = 1'b1;
            step();
            done = 1'b0;
            step();
        end

        // Hold limit forces release with a timeout pulse
        do_reset("r29_rst");
        req = 8'h08;
        step();
        for (int i = 1; i < MAX_HOLD; i++) begin
            chk("r29_held", gnt, 8'h08);
            step();
        end
        chk("r29_last_high", gnt, 8'h08);
        step();
        chk("r29_drop", gnt, 8'd0);
        chk("r29_timeout", {7'd0, timeout}, 8'd1);
        req = 8'h18;
        step();
        chk("r29_ptr4", {5'd0, gnt_idx}, 8'd4);
        chk("r29_pulse_end", {7'd0, timeout}, 8'd0);
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'd0;
        step();

        // Request drop and done-at-limit are normal releases
        do_reset("r31_rst");
        req = 8'h20;
        step();
        chk("r31_gnt5", gnt, 8'h20);
        req = 8'd0;
        step();
        chk("r31_drop", gnt, 8'd0);
        chk("r31_no_timeout", {7'd0, timeout}, 8'd0);
        req = 8'h20;
        step();
        for (int i = 1; i < MAX_HOLD; i++) step();
        chk("r31_still_held", gnt, 8'h20);
        done = 1'b1;
        step();
        chk("r31_limit_drop", gnt, 8'd0);
        chk("r31_limit_no_timeout", {7'd0, timeout}, 8'd0);
        done = 1'b0;
        req  = 8'd0;
        step();

        // Reset mid-grant, then pointer starts at 0
        do_reset("r32_pre");
        req = 8'h40;
        step();
        chk("r32_idx6", {5'd0, gnt_idx}, 8'd6);
        do_reset("r32_async");
        req = 8'h41;
        step();
        chk("r32_first_idx0", {5'd0, gnt_idx}, 8'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 7) == 0) req = 8'($urandom);
            if ($urandom_range(0, 15) == 0) req = 8'd0;
            done = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 249) == 0) do_reset("rand_rst");
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
